// File: rtl/vertex_fetch.sv
// Vertex fetch: reads x,y,z words from vertex BRAM and presents {x,y,z,1.0} per vertex.
// Latency: valid_out rises 3+BRAM_LATENCY cycles after a vertex fetch starts; no prefetch.
// Backpressure: pos/valid_out/obj_done_out held until ready_in; no BRAM reads while held.
module vertex_fetch #(
    parameter int ADDR_WIDTH   = 12,
    parameter int BRAM_LATENCY = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] base_addr_in,
    input  logic [CNT_WIDTH-1:0]  vertex_count_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [31:0]           data_in,
    output logic [31:0]           pos [3:0],
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  obj_done_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam logic [31:0]           ONE_F       = 32'h3f80_0000;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STRIDE = ADDR_WIDTH'(3);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        OUT,
        FINISH
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] vtx_addr;   // base + 3*i, advanced by 3 per vertex
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  idx;
    logic [1:0]            k;

    // Read-tag pipeline aligned to the BRAM latency: slot j holds the read issued j+1 cycles ago.
    logic [BRAM_LATENCY-1:0] pipe_vld;
    logic [1:0]              pipe_k [BRAM_LATENCY];

    logic start_acc;
    logic xfer;
    logic cap_vld;
    logic cap_last;
    logic is_last;

    assign cap_vld  = pipe_vld[BRAM_LATENCY-1];
    assign cap_last = cap_vld && (pipe_k[BRAM_LATENCY-1] == 2'd2);
    assign xfer     = (state == OUT) && valid_out && ready_in;
    assign is_last  = (idx == cnt - CNT_ONE);

    always_comb begin
        state_nxt  = state;
        start_acc  = 1'b0;
        done_out   = 1'b0;
        busy_out   = (state != IDLE);
        fetch_addr = vtx_addr + ADDR_WIDTH'(k);
        addr_out   = addr_hold;
        case (state)
            IDLE: begin
                if (start_in) begin
                    start_acc = 1'b1;
                    state_nxt = (vertex_count_in == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                addr_out = fetch_addr;
                if (k == 2'd2) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cap_last) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (xfer) begin
                    state_nxt = obj_done_out ? FINISH : FETCH;
                end
            end
            FINISH: begin
                done_out  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            vtx_addr     <= '0;
            addr_hold    <= '0;
            cnt          <= '0;
            idx          <= '0;
            k            <= '0;
            pipe_vld     <= '0;
            valid_out    <= 1'b0;
            obj_done_out <= 1'b0;
            pos[3]       <= '0;
            pos[2]       <= '0;
            pos[1]       <= '0;
            pos[0]       <= ONE_F;
            for (int j = 0; j < BRAM_LATENCY; j++) begin
                pipe_k[j] <= '0;
            end
        end else begin
            state <= state_nxt;

            if (start_acc) begin
                vtx_addr <= base_addr_in;
                cnt      <= vertex_count_in;
                idx      <= '0;
                k        <= '0;
            end

            if (state == FETCH) begin
                addr_hold <= fetch_addr;
                k         <= (k == 2'd2) ? 2'd0 : k + 2'd1;
            end

            pipe_vld[0] <= (state == FETCH);
            pipe_k[0]   <= k;
            for (int j = 1; j < BRAM_LATENCY; j++) begin
                pipe_vld[j] <= pipe_vld[j-1];
                pipe_k[j]   <= pipe_k[j-1];
            end

            if (cap_vld) begin
                case (pipe_k[BRAM_LATENCY-1])
                    2'd0:    pos[3] <= data_in;
                    2'd1:    pos[2] <= data_in;
                    default: pos[1] <= data_in;
                endcase
            end

            if (cap_last) begin
                valid_out    <= 1'b1;
                obj_done_out <= is_last;
            end else if (xfer) begin
                valid_out    <= 1'b0;
                obj_done_out <= 1'b0;
                if (!obj_done_out) begin
                    idx      <= idx + CNT_ONE;
                    vtx_addr <= vtx_addr + ADDR_STRIDE;
                end
            end
        end
    end

endmodule

// File: tb/tb_vertex_fetch.sv
// Bench for vertex_fetch: BRAM model, queue-based expected-vertex model, directed scenarios.
module tb_vertex_fetch;

    localparam int AW  = 12;
    localparam int LAT = 2;
    localparam int CW  = 16;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic [AW-1:0] base_addr_in;
    logic [CW-1:0] vertex_count_in;
    logic [AW-1:0] addr_out;
    logic [31:0]   data_in;
    logic [31:0]   pos [3:0];
    logic          valid_out;
    logic          ready_in;
    logic          obj_done_out;
    logic          busy_out;
    logic          done_out;

    always #5 clk_in = ~clk_in;

    vertex_fetch #(
        .ADDR_WIDTH  (AW),
        .BRAM_LATENCY(LAT),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .base_addr_in   (base_addr_in),
        .vertex_count_in(vertex_count_in),
        .addr_out       (addr_out),
        .data_in        (data_in),
        .pos            (pos),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .obj_done_out   (obj_done_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    // BRAM: data for the address presented in cycle c appears on data_in during cycle c+LAT.
    logic [31:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0] rd_pipe [LAT];
    always @(posedge clk_in) begin
        rd_pipe[0] <= addr_out;
        for (int j = 1; j < LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign data_in = mem[rd_pipe[LAT-1]];

    logic [127:0] pos_pk;
    assign pos_pk = {pos[3], pos[2], pos[1], pos[0]};

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected behaviour: every vertex of an object, in order, with its three words and last flag.
    logic [127:0]  exp_pos_q  [$];
    logic          exp_last_q [$];
    logic [AW-1:0] exp_addr_q [$];

    task automatic model_start(input logic [AW-1:0] b, input int c);
        logic [AW-1:0] a0, a1, a2;
        for (int i = 0; i < c; i++) begin
            a0 = b + AW'(3 * i);
            a1 = a0 + AW'(1);
            a2 = a0 + AW'(2);
            exp_pos_q.push_back({mem[a0], mem[a1], mem[a2], 32'h3f80_0000});
            exp_last_q.push_back(i == c - 1);
            exp_addr_q.push_back(a0);
            exp_addr_q.push_back(a1);
            exp_addr_q.push_back(a2);
        end
    endtask

    logic [AW-1:0] prev_addr = '0;
    logic [127:0]  prev_pos  = '0;
    logic          prev_hold = 1'b0;
    logic          prev_last = 1'b0;

    always @(negedge clk_in) begin
        if (rst_in) begin
            exp_pos_q.delete();
            exp_last_q.delete();
            exp_addr_q.delete();
            prev_hold = 1'b0;
            prev_addr = addr_out;
        end else begin
            if (addr_out != prev_addr) begin
                chk("addr_pending", exp_addr_q.size() != 0, 1'b1);
                if (exp_addr_q.size() != 0) chk("addr_seq", addr_out, exp_addr_q.pop_front());
            end
            if (prev_hold) begin
                chk("hold_vld", valid_out, 1'b1);
                chk("hold_pos", pos_pk, prev_pos);
                chk("hold_last", obj_done_out, prev_last);
            end
            if (valid_out && ready_in) begin
                chk("vtx_pending", exp_pos_q.size() != 0, 1'b1);
                if (exp_pos_q.size() != 0) begin
                    chk("vtx_pos", pos_pk, exp_pos_q.pop_front());
                    chk("vtx_last", obj_done_out, exp_last_q.pop_front());
                end
            end
            prev_hold = valid_out && !ready_in;
            prev_pos  = pos_pk;
            prev_last = obj_done_out;
            prev_addr = addr_out;
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Called 1 time unit into an IDLE cycle; returns 1 time unit into the following cycle.
    task automatic drive_start(input logic [AW-1:0] b, input logic [CW-1:0] c, output int s);
        start_in        = 1'b1;
        base_addr_in    = b;
        vertex_count_in = c;
        s               = cyc;
        step();
        start_in = 1'b0;
    endtask

    int   xfer_cyc  [$];
    logic xfer_last [$];

    task automatic run_until_done(input int bound, output int dcyc);
        bit found;
        found = 1'b0;
        dcyc  = -1;
        xfer_cyc.delete();
        xfer_last.delete();
        for (int n = 0; n < bound && !found; n++) begin
            if (valid_out && ready_in) begin
                xfer_cyc.push_back(cyc);
                xfer_last.push_back(obj_done_out);
            end
            if (done_out) begin
                found = 1'b1;
                dcyc  = cyc;
            end else begin
                step();
            end
        end
        chk("done_seen", found, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, dcyc, v;
        bit seen;
        logic [127:0] snap;

        for (int a = 0; a < (1 << AW); a++) mem[a] = 32'h4100_0000 | 32'(a * 7);
        mem[10] = 32'h3f80_0000;
        mem[11] = 32'h4000_0000;
        mem[12] = 32'h4040_0000;

        rst_in = 1'b1; start_in = 1'b0; ready_in = 1'b1;
        base_addr_in = '0; vertex_count_in = '0;
        #1;
        chk("rst_addr", addr_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_obj_done", obj_done_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_pos", pos_pk, 128'h0000_0000_0000_0000_0000_0000_3f80_0000);
        step(); step();
        rst_in = 1'b0;
        step();

        // Single vertex
        model_start(10, 1);
        drive_start(10, 1, s);
        chk("t1_addr0", addr_out, 10);
        chk("t1_busy", busy_out, 1);
        step(); chk("t1_addr1", addr_out, 11);
        step(); chk("t1_addr2", addr_out, 12);
        step(); step();
        chk("t1_vld_early", valid_out, 0);
        step();
        chk("t1_vld", valid_out, 1);
        chk("t1_pos", pos_pk, 128'h3f80_0000_4000_0000_4040_0000_3f80_0000);
        chk("t1_last", obj_done_out, 1);
        step();
        chk("t1_done", done_out, 1);
        chk("t1_vld_clr", valid_out, 0);
        step();
        chk("t1_done_pulse", done_out, 0);
        chk("t1_idle", busy_out, 0);

        // Three vertices, full throughput
        model_start(0, 3);
        drive_start(0, 3, s);
        run_until_done(40, dcyc);
        chk("t2_nxfer", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            chk("t2_first", xfer_cyc[0] - s, 6);
            chk("t2_gap1", xfer_cyc[1] - xfer_cyc[0], 6);
            chk("t2_gap2", xfer_cyc[2] - xfer_cyc[1], 6);
            chk("t2_lastflags", {xfer_last[0], xfer_last[1], xfer_last[2]}, 3'b001);
        end
        chk("t2_total", dcyc - s, 19);
        step();

        // Backpressure
        ready_in = 1'b0;
        model_start(100, 2);
        drive_start(100, 2, s);
        for (int n = 0; n < 12 && !valid_out; n++) step();
        chk("t3_vld_lat", cyc - s, 6);
        snap = pos_pk;
        v    = cyc;
        for (int n = 0; n < 7; n++) begin
            chk("t3_hold_vld", valid_out, 1);
            chk("t3_hold_pos", pos_pk, snap);
            chk("t3_hold_addr", addr_out, 102);
            step();
        end
        ready_in = 1'b1;
        chk("t3_release_cyc", cyc - v, 7);
        chk("t3_addr_at_xfer", addr_out, 102);
        step();
        chk("t3_refetch", addr_out, 103);
        chk("t3_vld_drop", valid_out, 0);
        run_until_done(40, dcyc);
        chk("t3_nxfer", xfer_cyc.size(), 1);
        step();

        // Empty object
        drive_start(200, 0, s);
        chk("t4_done", done_out, 1);
        chk("t4_addr", addr_out, 105);
        chk("t4_vld", valid_out, 0);
        step();
        chk("t4_done_pulse", done_out, 0);
        chk("t4_idle", busy_out, 0);
        step();

        // Start request while presenting a vertex is ignored
        ready_in = 1'b0;
        model_start(300, 2);
        drive_start(300, 2, s);
        for (int n = 0; n < 12 && !valid_out; n++) step();
        chk("t5_vld", valid_out, 1);
        start_in = 1'b1; base_addr_in = 500; vertex_count_in = 5;
        step();
        start_in = 1'b0;
        ready_in = 1'b1;
        run_until_done(40, dcyc);
        chk("t5_nxfer", xfer_cyc.size(), 2);
        step(); step(); step();
        chk("t5_idle", busy_out, 0);
        chk("t5_addr", addr_out, 305);

        // Address wrap, then reset in WAIT
        model_start(4094, 2);
        drive_start(4094, 2, s);
        chk("t6_addr0", addr_out, 4094);
        step(); chk("t6_addr1", addr_out, 4095);
        step(); chk("t6_addr2", addr_out, 0);
        step(); chk("t6_busy", busy_out, 1);
        rst_in = 1'b1;
        #1;
        chk("t6_rst_vld", valid_out, 0);
        chk("t6_rst_busy", busy_out, 0);
        chk("t6_rst_done", done_out, 0);
        chk("t6_rst_pos", pos_pk, 128'h0000_0000_0000_0000_0000_0000_3f80_0000);
        step(); step();
        rst_in = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (done_out || valid_out || busy_out) seen = 1'b1;
            step();
        end
        chk("t6_quiet", seen, 0);

        model_start(20, 1);
        drive_start(20, 1, s);
        run_until_done(20, dcyc);
        chk("t6_recover", xfer_cyc.size(), 1);
        chk("t6_recover_lat", dcyc - s, 7);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
